// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0), shown to the decoder before any fetch.
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Fetch FSM: IDLE waits for buffer space, REQ presents the request to
    // instruction memory, WAIT holds the single outstanding request.
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO that buffers fetched {pc, inst} pairs between instruction
// memory and the decoder. A flush empties it in one cycle (redirects).
module fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [63:0]              wr_data,
    output logic [63:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A push into a full buffer is only legal when an entry leaves in the same cycle.
    assign do_push = push && (!full || pop) && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Show-ahead read: the head entry is visible before it is popped.
    assign rd_data = mem[rd_ptr];

    // Storage write port.
    // NOTE: the data array has no reset; only the pointers and count define
    // which entries are valid, so clearing the storage would buy nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; flush discards everything in one cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the clock edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one request in flight
// to instruction memory, buffers returned words and hands them to the decoder
// with a one-cycle id_en strobe. Redirects flush the buffer and squash any
// response that belongs to the old instruction stream.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        id_en
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_e     state;
    fetch_state_e     state_next;
    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic [31:0]      req_addr;
    logic             discard;
    logic             discard_next;
    logic             outstanding;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] count_after;
    fetch_entry_t     wr_entry;
    fetch_entry_t     rd_entry;

    // Only the WAIT state has a request in flight.
    assign outstanding = (state == FETCH_WAIT);
    // Issue check counts the in-flight word so the buffer can never overflow.
    assign occupancy   = fifo_count + CNT_W'(outstanding);

    assign imem_req_o  = (state == FETCH_REQ);
    assign imem_addr_o = pc;

    // Deliver at most every other cycle so the decoder always sees a rising edge.
    assign pop = !fifo_empty && !stall_i && !redirect_i && !id_en;

    // The returned word is tagged with the address of the request that fetched it.
    assign wr_entry = '{pc: req_addr, inst: imem_rdata_i};

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_i),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    // Next-state, next-PC and squash logic; redirect overrides normal progress.
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        discard_next = discard;
        push         = 1'b0;
        count_after  = fifo_count;

        unique case (state)
            FETCH_IDLE: begin
                if (occupancy < DEPTH_CNT) begin
                    state_next = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (imem_gnt_i) begin
                    pc_next    = pc + 32'd4;
                    state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid_i) begin
                    if (discard) begin
                        discard_next = 1'b0;
                    end else begin
                        push = 1'b1;
                    end
                    count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);
                    state_next  = (count_after < DEPTH_CNT) ? FETCH_REQ : FETCH_IDLE;
                end
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase

        if (redirect_i) begin
            pc_next      = word_align(redirect_pc_i);
            push         = 1'b0;
            // A response still owed to the old stream must be thrown away.
            discard_next = ((state == FETCH_WAIT) && !imem_rvalid_i) ||
                           ((state == FETCH_REQ)  && imem_gnt_i);
            unique case (state)
                FETCH_REQ:  state_next = imem_gnt_i    ? FETCH_WAIT : FETCH_IDLE;
                FETCH_WAIT: state_next = imem_rvalid_i ? FETCH_IDLE : FETCH_WAIT;
                default:    state_next = FETCH_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PC, squash flag and the address of the request currently in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            discard  <= 1'b0;
            req_addr <= RESET_PC;
        end else begin
            pc      <= pc_next;
            discard <= discard_next;
            if ((state == FETCH_REQ) && imem_gnt_i) begin
                req_addr <= pc;
            end
        end
    end

    // Decoder interface: strobe plus held {pc, inst} of the last delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_o <= NOP_INST;
            pc_o   <= ZERO_WORD;
            id_en  <= 1'b0;
        end else begin
            id_en <= pop;
            if (pop) begin
                pc_o   <= rd_entry.pc;
                inst_o <= rd_entry.inst;
            end
        end
    end

endmodule
